// File: rtl/dm_copy_engine.sv
// Block copy / block fill initiator for the single-ported data memory.
// Copy alternates one read and one write per word; fill writes a constant every cycle.
module dm_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wrt_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  // Handshake: start is a request taken only in IDLE; completion is reported by a
  // single-cycle done (normal) or aborted pulse, with busy low in that cycle.
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d, wd_d;
  logic [DATA_W-1:0] wdata_d;
  logic              abort_fin;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    wd_d      = words_done;
    wdata_d   = mem_wrt_data;
    abort_fin = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wd_d = '0;
          if (len == '0) begin
            state_d = S_FIN;
          end else begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            state_d = mode ? S_FILL : S_RD;
            // The fill value lives in the write-data register for the whole fill.
            if (mode) wdata_d = fill_data;
          end
        end
      end
      S_RD: begin
        wdata_d = mem_rd_data;
        src_d   = src_q + ADDR_W'(1);
        if (abort) begin
          state_d   = S_FIN;
          abort_fin = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR, S_FILL: begin
        dst_d = dst_q + ADDR_W'(1);
        wd_d  = words_done + LEN_W'(1);
        rem_d = rem_q - LEN_W'(1);
        if (abort) begin
          state_d   = S_FIN;
          abort_fin = 1'b1;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = S_FIN;
        end else begin
          state_d = (state_q == S_WR) ? S_RD : S_FILL;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address for the coming cycle; held when the memory is idle.
  always_comb begin
    addr_d = mem_addr;
    case (state_d)
      S_RD:         addr_d = src_d;
      S_WR, S_FILL: addr_d = dst_d;
      default:      addr_d = mem_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      words_done   <= '0;
      mem_addr     <= '0;
      mem_wrt_data <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      words_done   <= wd_d;
      mem_addr     <= addr_d;
      mem_wrt_data <= wdata_d;
      mem_re       <= (state_d == S_RD);
      mem_we       <= (state_d == S_WR) || (state_d == S_FILL);
      busy         <= (state_d == S_RD) || (state_d == S_WR) || (state_d == S_FILL);
      done         <= (state_d == S_FIN) && !abort_fin;
      aborted      <= (state_d == S_FIN) && abort_fin;
    end
  end

endmodule

// File: doc/dm_copy_engine.md
Name: dm_copy_engine

Overview:
- Memory-side initiator for the single-ported data memory. It drives the memory's addr/re/we/wrt_data inputs and samples its rd_data output.
- Two modes: block copy (read a word from src, write it to dst, repeat) and block fill (write a constant to dst).
- Sits between a control register interface (start/len/addresses) and the DM. It never issues a read and a write in the same cycle.

Parameters:
- ADDR_W, 16, width of memory address and src/dst address inputs
- DATA_W, 16, memory word width
- LEN_W, 10, width of transfer length in words (max 2^LEN_W-1)

Ports:
- clk  input  1  system clock; memory samples on its falling edge, this block on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a transfer; sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill
- abort  input  1  terminate current transfer
- src_addr  input  ADDR_W  copy source base (ignored in fill)
- dst_addr  input  ADDR_W  destination base
- len  input  LEN_W  number of words
- fill_data  input  DATA_W  fill value
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse at normal completion
- aborted  output  1  one-cycle pulse at abort completion
- words_done  output  LEN_W  words written so far in current/last transfer
- mem_addr  output  ADDR_W  to DM addr
- mem_re  output  1  to DM re
- mem_we  output  1  to DM we
- mem_wrt_data  output  DATA_W  to DM wrt_data
- mem_rd_data  input  DATA_W  from DM rd_data

Behaviour:
- Reset: every output is 0, state is IDLE, and internal src/dst/remaining registers are 0. Reset asserted mid-transfer clears everything immediately. A pending memory access is dropped; mem_re/mem_we fall asynchronously.
- All outputs are registered. mem_re and mem_we are never both 1.
- States: IDLE, RD, WR, FILL, FIN.
- IDLE, start=1, len=0: no memory access, busy stays 0, done=1 next cycle, words_done=0.
- IDLE, start=1, len>0: latch src, dst, len, mode and fill_data; clear words_done. Next state is RD (mode=0) or FILL (mode=1). busy=1 from the following cycle.
- RD (1 cycle): mem_re=1, mem_addr=src. DM captures data on the falling edge. At the rising edge ending RD: mem_wrt_data <= mem_rd_data, src <= src+1, then go to WR.
- WR (1 cycle): mem_we=1, mem_addr=dst, mem_wrt_data holds the captured word. At the end: dst+1, words_done+1, remaining-1. Go to RD if remaining>0, else FIN.
- FILL (1 cycle per word): mem_we=1, mem_addr=dst, mem_wrt_data=fill_data. Increment and decrement as in WR. Stay in FILL until remaining=0, then go to FIN.
- FIN (1 cycle): busy=0, done=1, re/we=0, then IDLE.
- Latency, copy of N words: word i is read in cycle 2i+1 and written in cycle 2i+2 after the start edge. done pulses in cycle 2N+1. busy is high for exactly 2N cycles.
- Latency, fill of N words: writes occur in cycles 1..N. done pulses in cycle N+1.
- start while busy: ignored. No queuing.
- abort while busy, sampled at a rising edge:
  - If that edge ends RD: the read word is discarded and no write is issued.
  - If that edge ends WR or FILL: the write completes and is counted.
  - The next cycle is FIN with aborted=1 instead of done; words_done holds the count.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Address arithmetic: src and dst increment modulo 2^ADDR_W. Wrap from all-ones to 0 is silent.
- Overlap: transfers are strictly forward, one word at a time. If dst lies in (src, src+len), already-copied words are re-read. This is defined behaviour, not detected.
- mem_addr, mem_wrt_data: value is don't-care when re=we=0. A clean implementation holds the last value.

Test Plan:
- Preload DM[0x10..0x13]=A1,B2,C3,D4; copy src=0x10, dst=0x40, len=4 -> DM[0x40..0x43]=A1,B2,C3,D4. busy high 8 cycles, done in cycle 9, words_done=4. re/we alternate and never overlap.
- Fill dst=0x80, len=3, fill_data=0x5A5A -> DM[0x80..0x82]=0x5A5A. done in cycle 4. mem_re never asserted.
- len=0 with start -> busy stays 0, done pulses next cycle, no re/we activity.
- Copy len=6; abort during the 3rd RD -> exactly 2 words written, aborted pulses, done stays 0, words_done=2, DM[dst+2] unchanged.
- Copy src=0xFFFF, dst=0x0100, len=2 -> reads 0xFFFF then 0x0000, writes 0x0100, 0x0101. Second start issued mid-transfer is ignored.
- Assert rst_n=0 mid-WR -> mem_we, busy and words_done go to 0 immediately. After release, a new copy completes correctly.
